instr_fetch: RTL and testbench



---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/instr_fetch_if.sv | 33 +++
 rtl/fetch_buf.sv | 74 +++++++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the front end of the core.
// Provides the NOP encoding, the base opcode constants that decode also uses,
// the fetch-buffer entry type, the fetch FSM state type and small PC helpers.
package riscv_pkg;

    // Canonical NOP (addi x0, x0, 0). Presented to decode whenever nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Base-ISA major opcodes shared with decode.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Value held in an unoccupied buffer slot, so an empty head reads as NOP at PC 0.
    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

    // BOOT lasts one cycle after reset; RUN is normal operation.
    typedef enum logic [0:0] {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next sequential word address; wraps modulo 2^32.
    function automatic logic [31:0] next_word_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's external handshakes.
//   Decode side : run_en, flush, redirect_pc (in to fetch); ir, ir_already, pc (out of fetch)
//   Memory side : imem_req, imem_addr (out of fetch); imem_gnt, imem_rvalid, imem_rdata (in to fetch)
// master = the fetch stage, slave = the environment (decode + instruction memory).
interface instr_fetch_if;
    logic        run_en;
    logic        flush;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] ir;
    logic        ir_already;
    logic [31:0] pc;

    modport master (
        input  run_en, flush, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output ir, ir_already, pc
    );

    modport slave (
        output run_en, flush, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  ir, ir_already, pc
    );
endinterface

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO of fetch entries, built as a shift register so
// the head is always slot 0 and is read straight from a register.
// Unoccupied slots hold EMPTY_ENTRY, so an empty head reads as NOP / PC 0.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous discard of all entries (wins over push/pop)
//   push, push_entry  write an entry (ignored if it would overflow)
//   pop             remove the head (ignored when empty)
//   count           number of valid entries
//   head, head_valid  slot 0 contents and whether it is valid
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output fetch_entry_t  head,
    output logic          head_valid
);

    fetch_entry_t  mem_r [DEPTH];
    fetch_entry_t  mem_nxt_s [DEPTH];
    logic [CW-1:0] count_r;
    logic          head_valid_r;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [CW-1:0] wr_idx_s;
    logic [CW-1:0] count_nxt_s;

    // Accept/write-slot decode and next-state of every slot (shift on pop, write at tail).
    always_comb begin
        pop_ok_s    = pop && (count_r != {CW{1'b0}});
        wr_idx_s    = count_r - CW'(pop_ok_s);
        push_ok_s   = push && (wr_idx_s < CW'(DEPTH));
        count_nxt_s = wr_idx_s + CW'(push_ok_s);
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok_s && (wr_idx_s == CW'(i))) begin
                mem_nxt_s[i] = push_entry;
            end else if (pop_ok_s) begin
                // Last slot refills with EMPTY_ENTRY so vacated slots never carry stale data.
                mem_nxt_s[i] = (i < DEPTH - 1) ? mem_r[(i < DEPTH - 1) ? i + 1 : i] : EMPTY_ENTRY;
            end else begin
                mem_nxt_s[i] = mem_r[i];
            end
        end
    end

    // Storage, occupancy and registered head-valid flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EMPTY_ENTRY;
            end
            count_r      <= {CW{1'b0}};
            head_valid_r <= 1'b0;
        end else begin
            mem_r        <= mem_nxt_s;
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign count      = count_r;
    assign head       = mem_r[0];
    assign head_valid = head_valid_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues word reads over a req/gnt/rvalid handshake,
// buffers returned words with their PCs and presents the oldest to decode.
// A flush discards everything buffered and marks every in-flight request to be
// dropped on return, then refetches from the (word-aligned) redirect address.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    instr_fetch_if.master: decode handshake (run_en/flush/redirect_pc,
//          ir/ir_already/pc) and instruction-memory handshake (imem_*)
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     buffer entries; also the cap on live in-flight + buffered words (>= 2)
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_state_e  state_r;
    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [31:0]   pcq_r [DEPTH];
    logic [PW-1:0] pcq_wr_r;
    logic [PW-1:0] pcq_rd_r;

    logic [CW-1:0] fifo_count_s;
    fetch_entry_t  head_s;
    logic          head_valid_s;
    logic [CW-1:0] live_s;
    logic [SW-1:0] load_s;
    logic          rvalid_eff_s;
    logic          req_s;
    logic          gnt_fire_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  push_entry_s;

    // Circular pointer increment for the PC queue (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Issue decision and response classification.
    always_comb begin
        live_s = outstanding_r - drop_cnt_r;
        load_s = {1'b0, fifo_count_s} + {1'b0, live_s};
        // A response with nothing outstanding belongs to a request from before reset.
        rvalid_eff_s = bus.imem_rvalid && (outstanding_r != {CW{1'b0}});
        // A same-cycle pop is not credited. The total in-flight count (including
        // requests awaiting drop) is also capped so the counters and PC queue cannot wrap.
        if (!reset && (state_r == FETCH_RUN) && !bus.flush &&
            (load_s < SW'(DEPTH)) && (outstanding_r < CW'(DEPTH))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        gnt_fire_s   = req_s && bus.imem_gnt;
        push_s       = rvalid_eff_s && (drop_cnt_r == {CW{1'b0}}) && !bus.flush;
        pop_s        = bus.run_en && head_valid_s;
        push_entry_s = '{instr: bus.imem_rdata, pc: pcq_r[pcq_rd_r]};
    end

    // BOOT/RUN state, fetch address, request bookkeeping and the per-request PC queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH_BOOT;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            pcq_wr_r      <= {PW{1'b0}};
            pcq_rd_r      <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pcq_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                FETCH_BOOT: state_r <= FETCH_RUN;
                FETCH_RUN:  state_r <= FETCH_RUN;
                default:    state_r <= FETCH_BOOT;
            endcase

            outstanding_r <= outstanding_r + CW'(gnt_fire_s) - CW'(rvalid_eff_s);

            // The PC queue tracks every in-flight request, dropped or not, so it stays
            // aligned with the in-order response stream.
            if (gnt_fire_s) begin
                pcq_r[pcq_wr_r] <= fetch_pc_r;
                pcq_wr_r        <= ptr_inc(pcq_wr_r);
            end
            if (rvalid_eff_s) begin
                pcq_rd_r <= ptr_inc(pcq_rd_r);
            end

            if (bus.flush) begin
                // Everything still in flight after this edge is stale.
                drop_cnt_r <= outstanding_r - CW'(rvalid_eff_s);
                fetch_pc_r <= word_align(bus.redirect_pc);
            end else begin
                if (rvalid_eff_s && (drop_cnt_r != {CW{1'b0}})) begin
                    drop_cnt_r <= drop_cnt_r - CW'(1);
                end
                if (gnt_fire_s) begin
                    fetch_pc_r <= next_word_pc(fetch_pc_r);
                end
            end
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_fetch_buf (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.flush),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .count      (fifo_count_s),
        .head       (head_s),
        .head_valid (head_valid_s)
    );

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = fetch_pc_r;
    assign bus.ir         = head_s.instr;
    assign bus.pc         = head_s.pc;
    assign bus.ir_already = head_valid_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The memory model answers each granted request
// one cycle later (in order) with addr ^ 32'hA5A5_0000; responses can be held off
// to build up outstanding requests. Inputs change and outputs are sampled shortly
// after each rising edge.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    instr_fetch_if bus();

    logic [31:0] rq[$];
    bit          resp_en;
    logic [31:0] exp_pc;
    int          pops;
    int          nchk;
    int          nfail;
    bit          found;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic run, input logic fl, input logic [31:0] rpc, input logic g);
        bus.run_en      = run;
        bus.flush       = fl;
        bus.redirect_pc = rpc;
        bus.imem_gnt    = g;
        #1;
    endtask

    // Record this cycle's grant, cross the edge, then present the next response.
    task automatic edge_step();
        if (bus.imem_req && bus.imem_gnt) rq.push_back(bus.imem_addr ^ KEY);
        @(posedge clk);
        #1;
        if (resp_en && (rq.size() > 0)) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = rq.pop_front();
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hBAD0_BAD0;
        end
    endtask

    // Head must be the next expected PC (or NOP/0 when empty); advance on consume.
    task automatic stream_check();
        if (bus.ir_already) begin
            check32("head_pc", bus.pc, exp_pc);
            check32("head_ir", bus.ir, exp_pc ^ KEY);
            if (bus.run_en) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end else begin
            check32("empty_ir", bus.ir, NOP_INSTR);
            check32("empty_pc", bus.pc, 32'h0000_0000);
        end
    endtask

    task automatic run_stream(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1);
            stream_check();
            edge_step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        nchk = 0; nfail = 0; pops = 0; exp_pc = 32'h0;
        resp_en = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) edge_step();

        // Reset state
        check32("rst_valid", bus.ir_already, 1'b0);
        check32("rst_ir",    bus.ir, NOP_INSTR);
        check32("rst_pc",    bus.pc, 32'h0);
        check32("rst_req",   bus.imem_req, 1'b0);

        // Startup latency: BOOT, req, rvalid, visible
        reset = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("boot_req", bus.imem_req, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("c1_req",  bus.imem_req, 1'b1);
        check32("c1_addr", bus.imem_addr, 32'h0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("c2_valid", bus.ir_already, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("c3_valid", bus.ir_already, 1'b1);
        check32("c3_ir",    bus.ir, 32'hA5A5_0000);
        check32("c3_pc",    bus.pc, 32'h0);
        exp_pc = 32'h0;
        run_stream(12);

        // Stall: head stable, fetch fills the buffer then stops requesting
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            stream_check();
            edge_step();
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        check32("full_req",   bus.imem_req, 1'b0);
        check32("full_valid", bus.ir_already, 1'b1);
        check32("full_pc",    bus.pc, exp_pc);
        run_stream(10);

        // Flush to 0x10, hold two requests in flight, then flush to 0x203
        set_in(1'b1, 1'b1, 32'h10, 1'b0);
        check32("fl1_req", bus.imem_req, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h10, 1'b0);
        check32("fl1_clear", bus.ir_already, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        check32("hold_req",  bus.imem_req, 1'b1);
        check32("hold_addr", bus.imem_addr, 32'h10);
        edge_step();
        resp_en = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("out_a_addr", bus.imem_addr, 32'h10);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("out_b_req",  bus.imem_req, 1'b1);
        check32("out_b_addr", bus.imem_addr, 32'h14);
        edge_step();
        set_in(1'b1, 1'b1, 32'h203, 1'b1);
        check32("fl2_req", bus.imem_req, 1'b0);
        edge_step();
        resp_en = 1'b1;
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("fl2_clear", bus.ir_already, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
            check32("drop_empty", bus.ir_already, 1'b0);
            edge_step();
        end
        check32("redir_seen", found, 1'b1);
        check32("redir_addr", bus.imem_addr, 32'h200);
        exp_pc = 32'h200;
        run_stream(10);

        // Flush coinciding with rvalid and a pop of the single buffered entry
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.ir_already && bus.imem_rvalid) begin
                found = 1'b1;
                break;
            end
            stream_check();
            edge_step();
        end
        check32("coinc_seen", found, 1'b1);
        check32("coinc_pc", bus.pc, exp_pc);
        set_in(1'b1, 1'b1, 32'h300, 1'b1);
        check32("coinc_req", bus.imem_req, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("coinc_valid", bus.ir_already, 1'b0);
        check32("coinc_epc",   bus.pc, 32'h0);
        exp_pc = 32'h300;
        run_stream(10);

        // Redirect near the top of the address space: fetch wraps to 0
        set_in(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        edge_step();
        exp_pc = 32'hFFFF_FFF8;
        pops = 0;
        run_stream(12);
        check32("wrap_pops", (pops >= 3) ? 32'd1 : 32'd0, 32'd1);

        // Reset with two requests in flight; their late responses must be ignored
        resp_en = 1'b0;
        set_in(1'b0, 1'b1, 32'h400, 1'b1);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            edge_step();
        end
        check32("pre_rst_q", rq.size(), 32'd2);
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        edge_step();
        check32("rst2_valid", bus.ir_already, 1'b0);
        check32("rst2_ir",    bus.ir, NOP_INSTR);
        check32("rst2_pc",    bus.pc, 32'h0);
        check32("rst2_req",   bus.imem_req, 1'b0);
        resp_en = 1'b1;
        edge_step();
        reset = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("boot2_rvalid", bus.imem_rvalid, 1'b1);
        check32("boot2_req",    bus.imem_req, 1'b0);
        edge_step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        check32("restart_addr", bus.imem_addr, 32'h0);
        check32("restart_req",  bus.imem_req, 1'b1);
        exp_pc = 32'h0;
        pops = 0;
        run_stream(10);
        check32("restart_pops", (pops >= 3) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
